// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the RV32I dataPath.
// master = controller side (consumes IR and ALU flags, drives control word); slave = dataPath side.
interface multicycle_controller_if;
    logic [31:0] Instr;
    logic        Zero;
    logic        CarryOut;
    logic        Overflow;
    logic        Sign;
    logic        PCWrite;
    logic        AdrSrc;
    logic        MemWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [3:0]  ALUControl;
    logic [2:0]  ImmSrc;
    logic        Illegal;

    modport master (
        input  Instr, Zero, CarryOut, Overflow, Sign,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        output ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Illegal
    );

    modport slave (
        output Instr, Zero, CarryOut, Overflow, Sign,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        input  ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Illegal
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM + decoder sequencing the multicycle RV32I dataPath (3-5 clocks per instruction).
// Define ILLEGAL_TRAP_EN to park unknown opcodes in a HALT state with Illegal=1 until reset.
module multicycle_controller #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic clk,
    input  logic reset,
    multicycle_controller_if.master bus
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECR    = 4'd6;
    localparam logic [3:0] EXECI    = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BRANCH   = 4'd9;
    localparam logic [3:0] JAL      = 4'd10;
    localparam logic [3:0] JALR_ADR = 4'd11;
    localparam logic [3:0] JALR_PC  = 4'd12;
    localparam logic [3:0] LUI      = 4'd13;
    localparam logic [3:0] AUIPC    = 4'd14;
`ifdef ILLEGAL_TRAP_EN
    localparam logic [3:0] HALT     = 4'd15;
    localparam logic [3:0] ILL_NEXT = HALT;
`else
    localparam logic [3:0] ILL_NEXT = FETCH;
`endif

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    logic [3:0] state_q, state_d;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       unused_instr;

    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [3:0] alu_control, alu_op_ctl;
    logic [2:0] imm_src;
    logic       take, lt_signed;

    assign op           = bus.Instr[6:0];
    assign funct3       = bus.Instr[14:12];
    assign funct7b5     = bus.Instr[30];
    assign unused_instr = ^{bus.Instr[31], bus.Instr[29:15], bus.Instr[11:7]};

    // funct7b5 selects SUB only for register ops; for immediates bit30 is part of imm except SRAI.
    always_comb begin
        alu_op_ctl = ALU_ADD;
        case (funct3)
            3'b000:  alu_op_ctl = (op == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op_ctl = ALU_SLL;
            3'b010:  alu_op_ctl = ALU_SLT;
            3'b011:  alu_op_ctl = ALU_SLTU;
            3'b100:  alu_op_ctl = ALU_XOR;
            3'b101:  alu_op_ctl = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op_ctl = ALU_OR;
            default: alu_op_ctl = ALU_AND;
        endcase
    end

    assign lt_signed = bus.Sign ^ bus.Overflow;

    always_comb begin
        take = 1'b0;
        case (funct3)
            3'b000:  take = bus.Zero;
            3'b001:  take = ~bus.Zero;
            3'b100:  take = lt_signed;
            3'b101:  take = ~lt_signed;
            3'b110:  take = ~bus.CarryOut;
            3'b111:  take = bus.CarryOut;
            default: take = 1'b0;
        endcase
    end

    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_STORE:        imm_src = IMM_S;
            OP_BRANCH:       imm_src = IMM_B;
            OP_JAL:          imm_src = IMM_J;
            OP_LUI, OP_AUIPC: imm_src = IMM_U;
            default:         imm_src = IMM_I;
        endcase
    end

    always_comb begin
        state_d     = FETCH;
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        case (state_q)
            FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                state_d    = DECODE;
            end
            DECODE: begin
                // ALUOut = OldPC + imm: branch/JAL target computed speculatively here
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECR;
                    OP_ITYPE:          state_d = EXECI;
                    OP_BRANCH:         state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    OP_JALR:           state_d = JALR_ADR;
                    OP_LUI:            state_d = LUI;
                    OP_AUIPC:          state_d = AUIPC;
                    default:           state_d = ILL_NEXT;
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = alu_op_ctl;
                state_d     = ALUWB;
            end
            EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_op_ctl;
                state_d     = ALUWB;
            end
            ALUWB: reg_write = 1'b1;
            BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                pc_write    = take;
            end
            JAL, JALR_PC: begin
                // PC <- ALUOut (target) while ALU forms OldPC+4 for the link write
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = ALUWB;
            end
            JALR_ADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = JALR_PC;
            end
            LUI: begin
                result_src = 2'b11;
                reg_write  = 1'b1;
            end
            AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                state_d   = ALUWB;
            end
`ifdef ILLEGAL_TRAP_EN
            HALT: state_d = HALT;
`endif
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= RESET_STATE;
        else        state_q <= state_d;
    end

    // Write enables are gated by reset so an abandoned instruction never commits.
    assign bus.PCWrite    = pc_write & reset;
    assign bus.IRWrite    = ir_write & reset;
    assign bus.RegWrite   = reg_write & reset;
    assign bus.MemWrite   = mem_write & reset;
    assign bus.AdrSrc     = adr_src;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ALUControl = alu_control;
    assign bus.ImmSrc     = imm_src;
`ifdef ILLEGAL_TRAP_EN
    assign bus.Illegal    = (state_q == HALT);
`else
    assign bus.Illegal    = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: expected control words queued per instruction, popped and compared each cycle.
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    multicycle_controller_if bus ();
    multicycle_controller #(.RESET_STATE(4'd0)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [18:0] w;
    } exp_t;
    exp_t sb[$];

    function automatic logic [18:0] cw(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sbx,
                                       input logic [3:0] alu, input logic [2:0] imm,
                                       input logic ill);
        return {pcw, adr, mw, irw, rw, rs, sa, sbx, alu, imm, ill};
    endfunction

    function automatic logic [18:0] w_fetch(input logic [2:0] imm);
        return cw(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 4'd0, imm, 0);
    endfunction
    function automatic logic [18:0] w_decode(input logic [2:0] imm);
        return cw(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 4'd0, imm, 0);
    endfunction
    function automatic logic [18:0] w_aluwb(input logic [2:0] imm);
        return cw(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'd0, imm, 0);
    endfunction
    function automatic logic [18:0] w_rst(input logic [2:0] imm);
        return cw(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 4'd0, imm, 0);
    endfunction

    function automatic logic [18:0] observed();
        return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc, bus.Illegal};
    endfunction

    task automatic check(input string tag, input logic [18:0] exp);
        logic [18:0] got;
        got = observed();
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [18:0] w);
        exp_t e;
        e.tag = tag;
        e.w   = w;
        sb.push_back(e);
    endtask

    // Called at posedge+1; compares each queued word mid-cycle, then steps a clock.
    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            check(e.tag, e.w);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_alu(input string tag, input logic [31:0] ins, input logic rtype,
                           input logic [3:0] alu);
        bus.Instr = ins;
        push({tag, "_fetch"}, w_fetch(3'b000));
        push({tag, "_decode"}, w_decode(3'b000));
        push({tag, "_exec"}, cw(0, 0, 0, 0, 0, 2'b00, 2'b10, rtype ? 2'b00 : 2'b01, alu, 3'b000, 0));
        push({tag, "_wb"}, w_aluwb(3'b000));
        drain();
    endtask

    task automatic run_br(input string tag, input logic [2:0] f3, input logic z, input logic c,
                          input logic s, input logic o, input logic take);
        logic [31:0] ins;
        ins = 32'h00628063 | ({29'd0, f3} << 12);
        bus.Instr = ins;
        bus.Zero = z; bus.CarryOut = c; bus.Sign = s; bus.Overflow = o;
        push({tag, "_fetch"}, w_fetch(3'b010));
        push({tag, "_decode"}, w_decode(3'b010));
        push({tag, "_br"}, cw(take, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'd1, 3'b010, 0));
        drain();
        bus.Zero = 0; bus.CarryOut = 0; bus.Sign = 0; bus.Overflow = 0;
    endtask

    initial begin
        reset = 1'b0;
        bus.Instr = 32'h0;
        bus.Zero = 0; bus.CarryOut = 0; bus.Sign = 0; bus.Overflow = 0;

        @(negedge clk);
        check("reset_hold", w_rst(3'b000));
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;

        run_alu("add", 32'h00A28233, 1, 4'd0);
        run_alu("sub", 32'h40A28233, 1, 4'd1);
        run_alu("sra", 32'h40A2D233, 1, 4'd9);
        run_alu("srl", 32'h00A2D233, 1, 4'd8);
        run_alu("slt", 32'h00A2A233, 1, 4'd5);
        run_alu("or",  32'h00A2E233, 1, 4'd3);
        run_alu("xor", 32'h00A2C233, 1, 4'd4);
        run_alu("sll", 32'h00A29233, 1, 4'd7);
        run_alu("addi_b30", 32'h40028293, 0, 4'd0);
        run_alu("srai", 32'h4052D293, 0, 4'd9);
        run_alu("andi", 32'h0FF2F293, 0, 4'd2);
        run_alu("sltiu", 32'h0012B293, 0, 4'd6);

        bus.Instr = 32'h0042A303;
        push("lw_fetch", w_fetch(3'b000));
        push("lw_decode", w_decode(3'b000));
        push("lw_memadr", cw(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'd0, 3'b000, 0));
        push("lw_memread", cw(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 3'b000, 0));
        push("lw_memwb", cw(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 4'd0, 3'b000, 0));
        drain();

        bus.Instr = 32'h0062A223;
        push("sw_fetch", w_fetch(3'b001));
        push("sw_decode", w_decode(3'b001));
        push("sw_memadr", cw(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'd0, 3'b001, 0));
        push("sw_memwrite", cw(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 3'b001, 0));
        drain();

        run_br("beq_t", 3'b000, 1, 0, 0, 0, 1);
        run_br("beq_nt", 3'b000, 0, 0, 0, 0, 0);
        run_br("bne_t", 3'b001, 0, 0, 0, 0, 1);
        run_br("bltu_t", 3'b110, 0, 0, 0, 0, 1);
        run_br("bgeu_nt", 3'b111, 0, 0, 0, 0, 0);
        run_br("bge_t", 3'b101, 0, 0, 1, 1, 1);
        run_br("blt_t", 3'b100, 0, 1, 1, 0, 1);
        run_br("f3_010", 3'b010, 1, 1, 1, 0, 0);

        bus.Instr = 32'h008000EF;
        push("jal_fetch", w_fetch(3'b011));
        push("jal_decode", w_decode(3'b011));
        push("jal_jal", cw(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 4'd0, 3'b011, 0));
        push("jal_wb", w_aluwb(3'b011));
        drain();

        bus.Instr = 32'h000280E7;
        push("jalr_fetch", w_fetch(3'b000));
        push("jalr_decode", w_decode(3'b000));
        push("jalr_adr", cw(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'd0, 3'b000, 0));
        push("jalr_pc", cw(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 4'd0, 3'b000, 0));
        push("jalr_wb", w_aluwb(3'b000));
        drain();

        bus.Instr = 32'h12345297;
        push("auipc_fetch", w_fetch(3'b100));
        push("auipc_decode", w_decode(3'b100));
        push("auipc_exec", cw(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 4'd0, 3'b100, 0));
        push("auipc_wb", w_aluwb(3'b100));
        drain();

        // Unknown opcode: NOP back to FETCH, or HALT with Illegal when trapping.
        bus.Instr = 32'h0000007F;
        push("ill_fetch", w_fetch(3'b000));
        push("ill_decode", w_decode(3'b000));
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++)
            push("ill_halt", cw(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 3'b000, 1));
        drain();
        reset = 1'b0;
        #1 reset = 1'b1;
`else
        drain();
`endif

        // LUI right after also proves the illegal path returned to FETCH.
        bus.Instr = 32'h123452B7;
        push("lui_fetch", w_fetch(3'b100));
        push("lui_decode", w_decode(3'b100));
        push("lui_exec", cw(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 4'd0, 3'b100, 0));
        drain();

        // Reset mid-MEMWRITE: strobe must drop in the same cycle.
        bus.Instr = 32'h0062A223;
        push("swr_fetch", w_fetch(3'b001));
        push("swr_decode", w_decode(3'b001));
        push("swr_memadr", cw(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'd0, 3'b001, 0));
        drain();
        #1;
        check("swr_memwrite", cw(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 3'b001, 0));
        reset = 1'b0;
        #1;
        check("swr_reset_drop", w_rst(3'b001));
        @(posedge clk);
        #2;
        check("swr_reset_hold", w_rst(3'b001));
        reset = 1'b1;
        @(negedge clk);
        check("swr_refetch", w_fetch(3'b001));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
